mrv32_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core in bring-up (non-pipelined) mode. Owns the architectural PC and steps each instruction through FETCH, DECODE, EXECUTE, optional MEM, and WB. Drives the instruction/data memory handshakes and the writeback-stage valid token, and takes the commit pulse and next PC back from writeback. Also flags illegal instructions and memory timeouts, and counts retired instructions.

---
 rtl/mrv32_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mrv32_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrv32_ctrl.sv
// mrv32_ctrl -- multi-cycle sequencer for the RV32I core in bring-up mode.
//
// Steps each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// owns the architectural PC, the instruction register and the retired
// instruction counter, and traps (sticky until reset) on illegal encodings
// or memory handshakes that exceed MEM_TIMEOUT cycles.
//
// Parameters:
//   RESET_PC     PC loaded on reset
//   MEM_TIMEOUT  max wait cycles for imem_ack/dmem_ack (0 = never time out)
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_req/addr/ack/rdata     instruction fetch handshake (addr = pc)
//   ir, pc                      latched instruction word and its PC
//   dec_is_load/store/illegal   decoder classification of ir
//   ex_en                       one-cycle strobe to latch EX results
//   dmem_req/we/ack             data access handshake (we = store)
//   wb_valid                    writeback-stage valid token
//   instr_accept, pc_next       commit pulse and next PC from writeback
//   trap, trap_cause            sticky error flag and first cause
//   instret                     retired-instruction counter
module mrv32_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_illegal,
  output logic        ex_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        wb_valid,
  input  logic        instr_accept,
  input  logic [31:0] pc_next,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } cause_e;

  state_e             state_q, state_d;
  cause_e             cause_q, cause_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        instret_q, instret_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               live_q;
  logic               cnt_expire;

  // The reset state is FETCH, yet no request may be visible while rst_n is
  // held low. live_q is cleared by reset and set one edge after release, so
  // the FETCH request (and ack acceptance) starts in the first cycle after
  // the release edge without any input-to-output path.
  always_comb begin
    cnt_expire = (MEM_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == MEM_TIMEOUT);
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    cnt_d     = '0;
    we_d      = we_q;
    case (state_q)
      S_FETCH: begin
        if (live_q) begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = S_DECODE;
          end else if (cnt_expire) begin
            state_d = S_TRAP;
            cause_d = CAUSE_IMEM_TO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Store/load direction is captured here so dmem_we is a pure
        // function of registered state during MEM.
        we_d    = dec_is_store;
        state_d = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_expire) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        if (instr_accept) begin
          pc_d      = pc_next & 32'hFFFF_FFFC;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cause_q   <= CAUSE_NONE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    imem_req   = live_q && (state_q == S_FETCH);
    imem_addr  = pc_q;
    ir         = ir_q;
    pc         = pc_q;
    ex_en      = (state_q == S_EXEC);
    dmem_req   = (state_q == S_MEM);
    dmem_we    = (state_q == S_MEM) && we_q;
    wb_valid   = (state_q == S_WB);
    trap       = (state_q == S_TRAP);
    trap_cause = cause_q;
    instret    = instret_q;
  end

endmodule

// File: tb/tb_mrv32_ctrl.sv
// Self-checking bench for mrv32_ctrl: each instruction is described as a
// schedule (fetch wait, class, data wait, accept wait) and the expected
// output of every cycle is derived from that schedule.
module tb_mrv32_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int TO = 16;
  localparam int PH_Q = 0, PH_F = 1, PH_D = 2, PH_X = 3, PH_M = 4, PH_W = 5, PH_T = 6;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_ILL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        dec_is_load, dec_is_store, dec_illegal;
  logic        ex_en;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        wb_valid;
  logic        instr_accept;
  logic [31:0] pc_next;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  mrv32_ctrl #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_illegal(dec_illegal),
    .ex_en(ex_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .instr_accept(instr_accept), .pc_next(pc_next),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int obs_dreq = 0;
  int t_start, t_wb, t_commit;

  logic        chk_en = 1'b0;
  logic        e_imem_req, e_ex_en, e_dmem_req, e_dmem_we, e_wb, e_trap;
  logic [31:0] e_pc, e_ir, e_instret;
  logic [1:0]  e_cause;

  logic [31:0] m_pc, m_ir, m_instret;
  logic        m_trap, m_store;
  logic [1:0]  m_cause;

  logic        lit_en = 1'b0, lit_pc_en = 1'b0;
  logic [31:0] lit_pc, lit_instret;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("imem_req", imem_req, e_imem_req);
      chk32("imem_addr", imem_addr, e_pc);
      chk32("pc", pc, e_pc);
      chk32("ir", ir, e_ir);
      chk1("ex_en", ex_en, e_ex_en);
      chk1("dmem_req", dmem_req, e_dmem_req);
      if (e_dmem_req) chk1("dmem_we", dmem_we, e_dmem_we);
      chk1("wb_valid", wb_valid, e_wb);
      chk1("trap", trap, e_trap);
      chk32("trap_cause", {30'd0, trap_cause}, {30'd0, e_cause});
      chk32("instret", instret, e_instret);
      if (dmem_req === 1'b1) obs_dreq++;
    end
  end

  function automatic logic rb();
    return ($urandom() & 32'd1) != 32'd0;
  endfunction

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Inputs the DUT must ignore in the current phase get random values.
  task automatic junk();
    imem_ack     = rb();
    dmem_ack     = rb();
    instr_accept = rb();
    imem_rdata   = $urandom();
    pc_next      = $urandom();
  endtask

  task automatic expect_phase(input int ph);
    e_imem_req = (ph == PH_F);
    e_ex_en    = (ph == PH_X);
    e_dmem_req = (ph == PH_M);
    e_dmem_we  = (ph == PH_M) && m_store;
    e_wb       = (ph == PH_W);
    e_trap     = m_trap;
    e_cause    = m_cause;
    e_pc       = m_pc;
    e_ir       = m_ir;
    e_instret  = m_instret;
    chk_en     = 1'b1;
  endtask

  task automatic enter_trap(input logic [1:0] cause);
    m_trap  = 1'b1;
    m_cause = cause;
    for (int i = 0; i < 4; i++) begin
      begin_cycle();
      junk();
      expect_phase(PH_T);
    end
  endtask

  task automatic do_reset(input int n);
    begin_cycle();
    rst_n = 1'b0;
    junk();
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    instr_accept = 1'b1;
    chk_en = 1'b0;
    m_pc = RPC; m_ir = '0; m_instret = '0;
    m_trap = 1'b0; m_cause = 2'd0; m_store = 1'b0;
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      junk();
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      instr_accept = 1'b1;
      expect_phase(PH_Q);
    end
    begin_cycle();
    rst_n = 1'b1;
    junk();
    imem_ack = 1'b0;
    expect_phase(PH_Q);
  endtask

  // fw/dw/aw: wait cycles before imem_ack / dmem_ack / instr_accept.
  // A wait of TO or more never acks. rst_at >= 0 asserts reset in that MEM cycle.
  task automatic run_instr(input int kind, input int fw, input int dw, input int aw,
                           input logic [31:0] pcn, input int rst_at);
    logic [31:0] word;
    word = $urandom();
    obs_dreq = 0;
    t_start = cyc_n + 1;
    for (int i = 0; i < 1000; i++) begin
      begin_cycle();
      if (i == 0 && lit_en) begin
        chk32("instret_after_commit", instret, lit_instret);
        if (lit_pc_en) chk32("pc_after_commit", pc, lit_pc);
        lit_en = 1'b0;
        lit_pc_en = 1'b0;
      end
      junk();
      dec_illegal = rb(); dec_is_load = rb(); dec_is_store = rb();
      imem_ack = (i == fw);
      if (i == fw) imem_rdata = word;
      expect_phase(PH_F);
      if (i == fw) break;
      if (i == TO - 1) begin
        enter_trap(2'd2);
        return;
      end
    end
    m_ir = word;
    begin_cycle();
    junk();
    dec_illegal  = (kind == K_ILL);
    dec_is_load  = (kind == K_LD);
    dec_is_store = (kind == K_ST);
    expect_phase(PH_D);
    if (kind == K_ILL) begin
      enter_trap(2'd1);
      return;
    end
    begin_cycle();
    junk();
    expect_phase(PH_X);
    m_store = (kind == K_ST);
    if (kind == K_LD || kind == K_ST) begin
      for (int i = 0; i < 1000; i++) begin
        if (i == rst_at) begin
          do_reset(2);
          return;
        end
        begin_cycle();
        junk();
        dmem_ack = (i == dw);
        expect_phase(PH_M);
        if (i == dw) break;
        if (i == TO - 1) begin
          enter_trap(2'd3);
          return;
        end
      end
    end
    m_store = 1'b0;
    t_wb = cyc_n + 1;
    for (int i = 0; i <= aw; i++) begin
      begin_cycle();
      junk();
      instr_accept = (i == aw);
      if (i == aw) pc_next = pcn;
      expect_phase(PH_W);
    end
    t_commit = cyc_n;
    m_pc = pcn & 32'hFFFF_FFFC;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic pend(input logic pc_en, input logic [31:0] p, input logic [31:0] n);
    lit_en = 1'b1;
    lit_pc_en = pc_en;
    lit_pc = p;
    lit_instret = n;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; instr_accept = 1'b0;
    imem_rdata = '0; pc_next = '0;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_illegal = 1'b0;
    m_pc = RPC; m_ir = '0; m_instret = '0; m_trap = 1'b0; m_cause = 2'd0; m_store = 1'b0;

    do_reset(2);
    chk32("reset_pc", pc, 32'h0000_0100);
    chk1("reset_imem_req", imem_req, 1'b0);

    // ADDI, zero-wait: wb_valid in cycle 4, commit to 0x104.
    run_instr(K_ALU, 0, 0, 0, 32'h0000_0104, -1);
    chk32("alu_wb_cycle", t_wb - t_start + 1, 4);
    chk32("alu_total", t_commit - t_start + 1, 4);
    pend(1'b1, 32'h0000_0104, 32'd1);

    // Load with dmem_ack after 3 wait cycles.
    run_instr(K_LD, 0, 3, 0, 32'h0000_0108, -1);
    chk32("load_dmem_req_cycles", obs_dreq, 4);
    chk32("load_wb_cycle", t_wb - t_start + 1, 8);
    chk32("load_total", t_commit - t_start + 1, 8);
    pend(1'b1, 32'h0000_0108, 32'd2);

    // JAL redirect, misaligned low bits dropped.
    run_instr(K_ALU, 0, 0, 1, 32'h0000_0203, -1);
    pend(1'b1, 32'h0000_0200, 32'd3);

    run_instr(K_ST, 1, 0, 2, 32'h0000_0204, -1);
    pend(1'b1, 32'h0000_0204, 32'd4);

    // imem_ack in the 16th FETCH cycle wins over the timeout.
    run_instr(K_ALU, TO - 1, 0, 0, 32'h0000_0208, -1);
    chk32("fetch_ack_at_limit_wb", t_wb - t_start + 1, TO + 3);
    chk1("fetch_ack_at_limit_trap", trap, 1'b0);
    pend(1'b1, 32'h0000_0208, 32'd5);

    for (int n = 0; n < 200; n++) begin
      int k, fw, dw, aw;
      k  = int'($urandom_range(0, 2));
      fw = (($urandom() & 32'd3) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
      dw = (($urandom() & 32'd3) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
      aw = int'($urandom_range(0, 3));
      run_instr(k, fw, dw, aw, $urandom(), -1);
    end
    pend(1'b0, '0, 32'd205);

    // Illegal instruction: sticky trap, nothing retires.
    run_instr(K_ILL, 0, 0, 0, 32'h0, -1);
    chk1("illegal_trap", trap, 1'b1);
    chk32("illegal_cause", {30'd0, trap_cause}, 32'd1);
    chk32("illegal_instret", instret, 32'd205);

    do_reset(2);
    chk32("reset2_instret", instret, 32'd0);

    // imem never answers.
    run_instr(K_ALU, 1000, 0, 0, 32'h0, -1);
    chk32("imem_timeout_cause", {30'd0, trap_cause}, 32'd2);
    chk32("imem_timeout_pc", pc, 32'h0000_0100);

    // dmem never answers; ack at the limit is covered by the random loop.
    do_reset(1);
    run_instr(K_LD, 0, 1000, 0, 32'h0, -1);
    chk32("dmem_timeout_cause", {30'd0, trap_cause}, 32'd3);

    // Reset while dmem_req is high.
    do_reset(1);
    run_instr(K_ALU, 0, 0, 0, 32'h0000_0180, -1);
    run_instr(K_LD, 0, 5, 0, 32'h0, 2);
    chk32("mem_reset_pc", pc, 32'h0000_0100);
    chk32("mem_reset_instret", instret, 32'd0);
    chk1("mem_reset_dmem_req", dmem_req, 1'b0);

    run_instr(K_ST, 0, 0, 0, 32'h0000_0300, -1);
    pend(1'b1, 32'h0000_0300, 32'd1);
    run_instr(K_ALU, 0, 0, 0, 32'h0000_0304, -1);
    begin_cycle();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
